// File: rtl/vx_gpu_pkg.sv
// Shared scheduler types: decode next-state encoding, per-warp issue state,
// and the warp-id width helper.
package vx_gpu_pkg;

   typedef enum logic [1:0] {
      NS_ACTIVE = 2'd0,
      NS_BAR    = 2'd1,
      NS_HALT   = 2'd2,
      NS_RSVD   = 2'd3
   } next_state_e;

   typedef enum logic [1:0] {
      HALTED   = 2'd0,
      READY    = 2'd1,
      INFLIGHT = 2'd2,
      BLOCKED  = 2'd3
   } warp_state_e;

   // A single warp still needs a one-bit id.
   function automatic int nw_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vx_warp_stall_fsm.sv
// One warp's issue state plus its BLOCKED watchdog. Strobes arrive already
// decoded for this warp; an illegal strobe for the current state is ignored.
module vx_warp_stall_fsm
   import vx_gpu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1023,
   parameter bit INIT_READY     = 1'b0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        fetch_hit,
   input  logic        dec_hit,
   input  logic        dec_halt,
   input  logic        dec_block,
   input  logic        dec_unlock,
   input  logic        resolve_hit,
   input  logic        spawn,
   output warp_state_e state,
   output logic        timeout
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_TRIP = CW'(TIMEOUT_CYCLES - 1);

   warp_state_e   state_reg, state_next;
   logic [CW-1:0] cnt_reg;
   logic          timeout_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state_reg <= INIT_READY ? READY : HALTED;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         HALTED:   if (spawn) state_next = READY;
         READY:    if (fetch_hit) state_next = INFLIGHT;
         INFLIGHT: begin
            if (dec_hit) begin
               if (dec_halt)        state_next = HALTED;
               else if (dec_block)  state_next = BLOCKED;
               else if (dec_unlock) state_next = READY;
            end
         end
         BLOCKED:  if (resolve_hit) state_next = READY;
         default:  state_next = state_reg;
      endcase
   end

   // The count at the start of a cycle equals the BLOCKED cycles already
   // completed, so the flag trips as the TIMEOUT_CYCLES-th cycle ends.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_reg     <= '0;
         timeout_reg <= 1'b0;
      end else if (state_reg == BLOCKED) begin
         if (state_next != BLOCKED)
            cnt_reg <= '0;
         else if (cnt_reg != CNT_MAX)
            cnt_reg <= cnt_reg + 1'b1;
         if (cnt_reg >= CNT_TRIP)
            timeout_reg <= 1'b1;
      end else begin
         cnt_reg <= '0;
      end
   end

   assign state   = state_reg;
   assign timeout = timeout_reg;

endmodule

// File: rtl/vx_warp_stall_ctrl.sv
// Warp issue-eligibility controller: decodes fetch/decode/resolve/spawn events
// per warp, exports state masks, a PC-increment hint and sticky error flags.
module vx_warp_stall_ctrl
   import vx_gpu_pkg::*;
#(
   parameter int NUM_WARPS      = 4,
   parameter int NW_WIDTH       = nw_width(NUM_WARPS),
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 fetch_fire,
   input  logic [NW_WIDTH-1:0]  fetch_wid,
   input  logic                 dec_valid,
   input  logic                 dec_unlock,
   input  logic [NW_WIDTH-1:0]  dec_wid,
   input  logic                 dec_rvc,
   input  logic                 dec_stall,
   input  logic [1:0]           dec_next_state,
   input  logic                 resolve_valid,
   input  logic [NW_WIDTH-1:0]  resolve_wid,
   input  logic [NUM_WARPS-1:0] spawn_mask,
   output logic [NUM_WARPS-1:0] ready_mask,
   output logic [NUM_WARPS-1:0] blocked_mask,
   output logic [NUM_WARPS-1:0] halted_mask,
   output logic                 pc_inc_valid,
   output logic [NW_WIDTH-1:0]  pc_inc_wid,
   output logic [2:0]           pc_inc_bytes,
   output logic [NUM_WARPS-1:0] timeout,
   output logic                 proto_err
);

   next_state_e            ns;
   logic                   dec_halt, dec_block;
   logic [NUM_WARPS-1:0]   fetch_hit, dec_hit, resolve_hit;
   logic [NUM_WARPS-1:0]   ready_vec, inflight_vec, blocked_vec, halted_vec;
   logic                   fetch_err, dec_ok, dec_err, resolve_err;
   logic                   proto_err_reg;
   logic                   pc_inc_valid_reg;
   logic [NW_WIDTH-1:0]    pc_inc_wid_reg;
   logic [2:0]             pc_inc_bytes_reg;

   assign ns        = next_state_e'(dec_next_state);
   assign dec_halt  = (ns == NS_HALT);
   assign dec_block = dec_stall || (ns == NS_BAR);

   for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
      warp_state_e warp_state;

      assign fetch_hit[gi]   = fetch_fire    && (fetch_wid   == NW_WIDTH'(gi));
      assign dec_hit[gi]     = dec_valid     && (dec_wid     == NW_WIDTH'(gi));
      assign resolve_hit[gi] = resolve_valid && (resolve_wid == NW_WIDTH'(gi));

      vx_warp_stall_fsm #(
         .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
         .INIT_READY     (gi == 0)
      ) u_fsm (
         .clk         (clk),
         .reset_n     (reset_n),
         .fetch_hit   (fetch_hit[gi]),
         .dec_hit     (dec_hit[gi]),
         .dec_halt    (dec_halt),
         .dec_block   (dec_block),
         .dec_unlock  (dec_unlock),
         .resolve_hit (resolve_hit[gi]),
         .spawn       (spawn_mask[gi]),
         .state       (warp_state),
         .timeout     (timeout[gi])
      );

      assign ready_vec[gi]    = (warp_state == READY);
      assign inflight_vec[gi] = (warp_state == INFLIGHT);
      assign blocked_vec[gi]  = (warp_state == BLOCKED);
      assign halted_vec[gi]   = (warp_state == HALTED);
   end

   // An out-of-range wid matches no warp, so it lands in the error terms too.
   assign fetch_err   = fetch_fire    && !(|(fetch_hit   & ready_vec));
   assign dec_ok      = dec_valid     &&  (|(dec_hit     & inflight_vec));
   assign dec_err     = dec_valid     && !dec_ok;
   assign resolve_err = resolve_valid && !(|(resolve_hit & blocked_vec));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         proto_err_reg    <= 1'b0;
         pc_inc_valid_reg <= 1'b0;
         pc_inc_wid_reg   <= '0;
         pc_inc_bytes_reg <= 3'd0;
      end else begin
         if (fetch_err || dec_err || resolve_err)
            proto_err_reg <= 1'b1;
         pc_inc_valid_reg <= dec_ok;
         if (dec_ok) begin
            pc_inc_wid_reg   <= dec_wid;
            pc_inc_bytes_reg <= dec_rvc ? 3'd2 : 3'd4;
         end
      end
   end

   assign ready_mask   = ready_vec;
   assign blocked_mask = blocked_vec;
   assign halted_mask  = halted_vec;
   assign pc_inc_valid = pc_inc_valid_reg;
   assign pc_inc_wid   = pc_inc_wid_reg;
   assign pc_inc_bytes = pc_inc_bytes_reg;
   assign proto_err    = proto_err_reg;

endmodule

// File: tb/tb_vx_warp_stall_ctrl.sv
// Directed bench for vx_warp_stall_ctrl with a short watchdog (7 cycles);
// each task drives one scenario and checks hand-computed expectations inline.
module tb_vx_warp_stall_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       fetch_fire;
   logic [1:0] fetch_wid;
   logic       dec_valid, dec_unlock, dec_rvc, dec_stall;
   logic [1:0] dec_wid, dec_next_state;
   logic       resolve_valid;
   logic [1:0] resolve_wid;
   logic [3:0] spawn_mask;
   logic [3:0] ready_mask, blocked_mask, halted_mask, timeout;
   logic       pc_inc_valid, proto_err;
   logic [1:0] pc_inc_wid;
   logic [2:0] pc_inc_bytes;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   vx_warp_stall_ctrl #(
      .NUM_WARPS      (4),
      .NW_WIDTH       (2),
      .TIMEOUT_CYCLES (7)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .fetch_fire     (fetch_fire),
      .fetch_wid      (fetch_wid),
      .dec_valid      (dec_valid),
      .dec_unlock     (dec_unlock),
      .dec_wid        (dec_wid),
      .dec_rvc        (dec_rvc),
      .dec_stall      (dec_stall),
      .dec_next_state (dec_next_state),
      .resolve_valid  (resolve_valid),
      .resolve_wid    (resolve_wid),
      .spawn_mask     (spawn_mask),
      .ready_mask     (ready_mask),
      .blocked_mask   (blocked_mask),
      .halted_mask    (halted_mask),
      .pc_inc_valid   (pc_inc_valid),
      .pc_inc_wid     (pc_inc_wid),
      .pc_inc_bytes   (pc_inc_bytes),
      .timeout        (timeout),
      .proto_err      (proto_err)
   );

   task automatic clear_inputs();
      fetch_fire = 0; fetch_wid = 0;
      dec_valid = 0; dec_unlock = 0; dec_wid = 0; dec_rvc = 0; dec_stall = 0; dec_next_state = 0;
      resolve_valid = 0; resolve_wid = 0; spawn_mask = 0;
   endtask

   // Apply whatever is driven for one edge, then sample 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
      clear_inputs();
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      reset_n = 0;
      #1;
      n_chk++; if (halted_mask !== 4'b1110) begin n_fail++; $display("FAIL reset_async halted_mask got %b exp 1110", halted_mask); end
      repeat (2) @(posedge clk);
      #1 reset_n = 1;
      step();
      n_chk++; if (ready_mask !== 4'b0001) begin n_fail++; $display("FAIL reset ready_mask got %b exp 0001", ready_mask); end
      n_chk++; if (blocked_mask !== 4'b0000) begin n_fail++; $display("FAIL reset blocked_mask got %b exp 0000", blocked_mask); end
      n_chk++; if (halted_mask !== 4'b1110) begin n_fail++; $display("FAIL reset halted_mask got %b exp 1110", halted_mask); end
      n_chk++; if (pc_inc_valid !== 1'b0) begin n_fail++; $display("FAIL reset pc_inc_valid got %b exp 0", pc_inc_valid); end
      n_chk++; if (pc_inc_wid !== 2'd0) begin n_fail++; $display("FAIL reset pc_inc_wid got %0d exp 0", pc_inc_wid); end
      n_chk++; if (pc_inc_bytes !== 3'd0) begin n_fail++; $display("FAIL reset pc_inc_bytes got %0d exp 0", pc_inc_bytes); end
      n_chk++; if (timeout !== 4'b0000) begin n_fail++; $display("FAIL reset timeout got %b exp 0000", timeout); end
      n_chk++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset proto_err got %b exp 0", proto_err); end
      $display("reset: ready=%b halted=%b", ready_mask, halted_mask);
   endtask

   task automatic test_unlock();
      fetch_fire = 1; fetch_wid = 0;
      step();
      n_chk++; if (ready_mask !== 4'b0000) begin n_fail++; $display("FAIL unlock_fetch ready_mask got %b exp 0000", ready_mask); end
      dec_valid = 1; dec_wid = 0; dec_unlock = 1; dec_rvc = 1;
      step();
      n_chk++; if (ready_mask !== 4'b0001) begin n_fail++; $display("FAIL unlock_dec ready_mask got %b exp 0001", ready_mask); end
      n_chk++; if (pc_inc_valid !== 1'b1) begin n_fail++; $display("FAIL unlock_hint valid got %b exp 1", pc_inc_valid); end
      n_chk++; if (pc_inc_wid !== 2'd0) begin n_fail++; $display("FAIL unlock_hint wid got %0d exp 0", pc_inc_wid); end
      n_chk++; if (pc_inc_bytes !== 3'd2) begin n_fail++; $display("FAIL unlock_hint bytes got %0d exp 2", pc_inc_bytes); end
      step();
      n_chk++; if (pc_inc_valid !== 1'b0) begin n_fail++; $display("FAIL unlock_hint_drop valid got %b exp 0", pc_inc_valid); end
      n_chk++; if (pc_inc_bytes !== 3'd2) begin n_fail++; $display("FAIL unlock_hint_hold bytes got %0d exp 2", pc_inc_bytes); end
      $display("unlock: w0 fetched, unlocked, hint bytes=%0d", pc_inc_bytes);
   endtask

   task automatic test_stall();
      spawn_mask = 4'b0010;
      step();
      n_chk++; if (ready_mask !== 4'b0011) begin n_fail++; $display("FAIL stall_spawn ready_mask got %b exp 0011", ready_mask); end
      n_chk++; if (halted_mask !== 4'b1100) begin n_fail++; $display("FAIL stall_spawn halted_mask got %b exp 1100", halted_mask); end
      fetch_fire = 1; fetch_wid = 1;
      step();
      dec_valid = 1; dec_wid = 1; dec_stall = 1; dec_unlock = 1; dec_rvc = 0;
      step();
      n_chk++; if (pc_inc_wid !== 2'd1 || pc_inc_bytes !== 3'd4) begin n_fail++; $display("FAIL stall_hint wid/bytes got %0d/%0d exp 1/4", pc_inc_wid, pc_inc_bytes); end
      for (int c = 1; c <= 5; c++) begin
         n_chk++; if (blocked_mask !== 4'b0010 || ready_mask !== 4'b0001) begin n_fail++; $display("FAIL stall_blocked cycle %0d blocked/ready got %b/%b exp 0010/0001", c, blocked_mask, ready_mask); end
         if (c == 5) begin resolve_valid = 1; resolve_wid = 1; end
         step();
      end
      n_chk++; if (blocked_mask !== 4'b0000 || ready_mask !== 4'b0011) begin n_fail++; $display("FAIL stall_resolve blocked/ready got %b/%b exp 0000/0011", blocked_mask, ready_mask); end
      n_chk++; if (timeout !== 4'b0000 || proto_err !== 1'b0) begin n_fail++; $display("FAIL stall_flags timeout/proto_err got %b/%b exp 0000/0", timeout, proto_err); end
      $display("stall: w1 blocked 5 cycles then ready=%b", ready_mask);
   endtask

   task automatic test_halt();
      fetch_fire = 1; fetch_wid = 0;
      step();
      dec_valid = 1; dec_wid = 0; dec_next_state = 2'd2; dec_unlock = 1;
      step();
      n_chk++; if (halted_mask !== 4'b1101 || ready_mask !== 4'b0010) begin n_fail++; $display("FAIL halt_dec halted/ready got %b/%b exp 1101/0010", halted_mask, ready_mask); end
      n_chk++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL halt_clean proto_err got %b exp 0", proto_err); end
      fetch_fire = 1; fetch_wid = 0;
      step();
      n_chk++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL halt_fetch proto_err got %b exp 1", proto_err); end
      n_chk++; if (halted_mask !== 4'b1101 || ready_mask !== 4'b0010) begin n_fail++; $display("FAIL halt_keep halted/ready got %b/%b exp 1101/0010", halted_mask, ready_mask); end
      $display("halt: w0 halted, fetch to halted warp flagged proto_err=%b", proto_err);
   endtask

   task automatic test_watchdog();
      spawn_mask = 4'b0100;
      step();
      fetch_fire = 1; fetch_wid = 2;
      step();
      dec_valid = 1; dec_wid = 2; dec_next_state = 2'd1;
      step();
      n_chk++; if (blocked_mask !== 4'b0100) begin n_fail++; $display("FAIL wd_bar blocked_mask got %b exp 0100", blocked_mask); end
      repeat (6) step();
      n_chk++; if (timeout !== 4'b0000) begin n_fail++; $display("FAIL wd_early timeout got %b exp 0000", timeout); end
      step();
      n_chk++; if (timeout !== 4'b0100) begin n_fail++; $display("FAIL wd_trip timeout got %b exp 0100", timeout); end
      n_chk++; if (blocked_mask !== 4'b0100) begin n_fail++; $display("FAIL wd_noforce blocked_mask got %b exp 0100", blocked_mask); end
      resolve_valid = 1; resolve_wid = 2;
      step();
      n_chk++; if (ready_mask !== 4'b0101 || timeout !== 4'b0100) begin n_fail++; $display("FAIL wd_sticky ready/timeout got %b/%b exp 0101/0100", ready_mask, timeout); end
      n_chk++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL wd_clean proto_err got %b exp 0", proto_err); end
      $display("watchdog: timeout=%b after resolve", timeout);
   endtask

   task automatic test_back_to_back();
      spawn_mask = 4'b1110;
      step();
      fetch_fire = 1; fetch_wid = 1;
      step();
      fetch_fire = 1; fetch_wid = 2;
      step();
      dec_valid = 1; dec_wid = 2; dec_stall = 1;
      step();
      n_chk++; if (ready_mask !== 4'b1001 || blocked_mask !== 4'b0100) begin n_fail++; $display("FAIL b2b_setup ready/blocked got %b/%b exp 1001/0100", ready_mask, blocked_mask); end
      fetch_fire = 1; fetch_wid = 3;
      dec_valid = 1; dec_wid = 1; dec_unlock = 1; dec_rvc = 1;
      resolve_valid = 1; resolve_wid = 2;
      step();
      n_chk++; if (ready_mask !== 4'b0111) begin n_fail++; $display("FAIL b2b_ready ready_mask got %b exp 0111", ready_mask); end
      n_chk++; if (blocked_mask !== 4'b0000 || halted_mask !== 4'b0000) begin n_fail++; $display("FAIL b2b_masks blocked/halted got %b/%b exp 0000/0000", blocked_mask, halted_mask); end
      n_chk++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL b2b_proto proto_err got %b exp 0", proto_err); end
      n_chk++; if (pc_inc_valid !== 1'b1 || pc_inc_wid !== 2'd1 || pc_inc_bytes !== 3'd2) begin n_fail++; $display("FAIL b2b_hint v/wid/bytes got %b/%0d/%0d exp 1/1/2", pc_inc_valid, pc_inc_wid, pc_inc_bytes); end
      $display("back_to_back: ready=%b proto_err=%b", ready_mask, proto_err);
   endtask

   task automatic test_bad_decode();
      dec_valid = 1; dec_wid = 0; dec_unlock = 1; dec_rvc = 0;
      step();
      n_chk++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL bad_dec proto_err got %b exp 1", proto_err); end
      n_chk++; if (pc_inc_valid !== 1'b0 || pc_inc_bytes !== 3'd2) begin n_fail++; $display("FAIL bad_dec_hint valid/bytes got %b/%0d exp 0/2", pc_inc_valid, pc_inc_bytes); end
      n_chk++; if (ready_mask !== 4'b0111) begin n_fail++; $display("FAIL bad_dec_keep ready_mask got %b exp 0111", ready_mask); end
      $display("bad_decode: decode to READY w0 flagged proto_err=%b", proto_err);
   endtask

   initial begin
      reset_n = 1;
      clear_inputs();
      test_reset();
      test_unlock();
      test_stall();
      test_halt();
      test_reset();
      test_watchdog();
      test_reset();
      test_back_to_back();
      test_bad_decode();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/vx_warp_stall_ctrl.md
Name: vx_warp_stall_ctrl

Overview:
- Per-warp issue-eligibility controller in the warp scheduler; consumes decode-to-scheduler feedback (valid/unlock/wid/rvc/stall/next_state).
- Locks a warp when fetch takes an instruction from it. Releases, blocks or halts the warp based on decode feedback.
- Exports a ready mask to the warp selector.
- Adds a watchdog on blocked warps and a registered PC-increment hint derived from rvc.

Parameters:
- NUM_WARPS, 4, number of warps tracked.
- NW_WIDTH, $clog2(NUM_WARPS) (min 1), warp-id width.
- TIMEOUT_CYCLES, 1023, cycles a warp may stay BLOCKED before the timeout flag is raised.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- fetch_fire  in  1  fetch accepted an instruction from fetch_wid
- fetch_wid  in  NW_WIDTH  warp fetched
- dec_valid  in  1  decode feedback valid
- dec_unlock  in  1  instruction needs no further hold; warp may issue again
- dec_wid  in  NW_WIDTH  warp of the feedback
- dec_rvc  in  1  decoded instruction is compressed (2 bytes)
- dec_stall  in  1  instruction blocks the warp until resolved
- dec_next_state  in  2  encoded next warp state (package enum)
- resolve_valid  in  1  branch/barrier resolution for resolve_wid
- resolve_wid  in  NW_WIDTH  warp resolved
- spawn_mask  in  NUM_WARPS  warps to (re)activate from HALTED
- ready_mask  out  NUM_WARPS  warps eligible for fetch
- blocked_mask  out  NUM_WARPS  warps in BLOCKED
- halted_mask  out  NUM_WARPS  warps in HALTED
- pc_inc_valid  out  1  registered PC-increment hint valid
- pc_inc_wid  out  NW_WIDTH  warp of the hint
- pc_inc_bytes  out  3  2 if rvc, else 4
- timeout  out  NUM_WARPS  sticky per-warp watchdog flag
- proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset is asynchronous, active-low. Every warp goes to HALTED except warp 0, which goes to READY.
  - Reset values: ready_mask=1, blocked_mask=0, halted_mask=~1, pc_inc_valid=0, pc_inc_wid=0, pc_inc_bytes=0, timeout=0, proto_err=0, all counters=0.
  - Reset mid-operation discards all in-flight state.
- Per-warp FSM states: HALTED, READY, INFLIGHT, BLOCKED. All state updates occur on the clock edge. Output masks are decoded combinationally from the state registers.
- READY --fetch_fire&&fetch_wid==w--> INFLIGHT.
- INFLIGHT, on dec_valid&&dec_wid==w, priority from highest to lowest:
  - dec_next_state==NS_HALT -> HALTED.
  - dec_stall -> BLOCKED.
  - dec_unlock -> READY.
  - Otherwise stays INFLIGHT (multi-cycle decode).
- BLOCKED --resolve_valid&&resolve_wid==w--> READY.
- HALTED --spawn_mask[w]--> READY. spawn_mask bits for warps not HALTED are ignored; no error.
- dec_next_state==NS_BAR behaves as stall. NS_ACTIVE and NS_RSVD defer to stall/unlock.
- Events targeting different warps in the same cycle are all applied independently.
- Protocol errors (warp keeps its state, proto_err set sticky until reset):
  - fetch for a warp not READY;
  - decode for a warp not INFLIGHT;
  - resolve for a warp not BLOCKED.
- PC-increment hint, 1-cycle latency:
  - On every dec_valid, the next cycle drives pc_inc_valid=1, pc_inc_wid=dec_wid, pc_inc_bytes = dec_rvc ? 2 : 4.
  - pc_inc_wid and pc_inc_bytes hold their last value when valid=0.
  - Not issued for a protocol-error decode.
- Watchdog:
  - Per-warp counter of width $clog2(TIMEOUT_CYCLES+1). It increments each cycle in BLOCKED and clears on leaving BLOCKED.
  - It saturates at TIMEOUT_CYCLES. On reaching TIMEOUT_CYCLES, timeout[w] is set and stays set until reset.
  - The state is not forced; the warp still leaves BLOCKED normally on resolve.
- dec_wid/fetch_wid/resolve_wid values >= NUM_WARPS are a protocol error; the event is ignored.

Decomposition:
- Shared package (VX_gpu_pkg):
  - next_state enum: NS_ACTIVE=0, NS_BAR=1, NS_HALT=2, NS_RSVD=3.
  - warp-state enum: HALTED=0, READY=1, INFLIGHT=2, BLOCKED=3.
  - Reuse NW_WIDTH.
- One natural sub-module: vx_warp_stall_fsm, instantiated NUM_WARPS times. It holds one warp's state and watchdog counter, with decoded hit strobes as inputs.

Test Plan:
- Reset release: ready_mask=0001, halted_mask=1110, all other outputs 0.
- Unlock path:
  - Stimulus: fetch w0, then next cycle dec_valid wid0 unlock=1 rvc=1.
  - Response: ready_mask 0000 then 0001; following cycle pc_inc_valid=1, wid=0, bytes=2.
- Stall path:
  - Stimulus: spawn_mask=0010, fetch w1, decode w1 stall=1 unlock=1, resolve w1 five cycles later.
  - Response: blocked_mask=0010 for exactly 5 cycles, then ready_mask includes w1. stall beats unlock.
- Halt: decode w0 next_state=NS_HALT with unlock=1 -> halted_mask bit0=1; a fetch to w0 afterward sets proto_err=1.
- Watchdog (TIMEOUT_CYCLES=7): block w2, no resolve -> timeout[2] rises on the 7th BLOCKED cycle and stays 1 after a later resolve.
- Same-cycle events: fetch w3 + decode-unlock w1 + resolve w2 in one cycle -> all three transitions applied, proto_err=0.
